config_mode_param: RTL and testbench



---
 rtl/config_mode_param.sv | 191 +++++++++++++++++++
 tb/tb_config_mode_param.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/config_mode_param.sv
// Traffic-light timing editor: edits red/green/yellow times with buttons,
// validates and commits them, and shows the time being edited on both lanes.
module config_mode_param #(
  parameter int TIME_W     = 7,
  parameter int MIN_TIME   = 1,
  parameter int MAX_TIME   = 99,
  parameter int WRAP       = 1,
  parameter int REPEAT_DLY = 50,
  parameter int REPEAT_PER = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              buttonChangeLight,
  input  logic              buttonIncreaseTime,
  input  logic              buttonDecreaseTime,
  input  logic              buttonConfirm,
  input  logic              buttonCancel,
  input  logic [TIME_W-1:0] greenTime,
  input  logic [TIME_W-1:0] yellowTime,
  input  logic [TIME_W-1:0] redTime,
  output logic [TIME_W-1:0] greenTimeModified,
  output logic [TIME_W-1:0] yellowTimeModified,
  output logic [TIME_W-1:0] redTimeModified,
  output logic [TIME_W-1:0] timeLane1,
  output logic [TIME_W-1:0] timeLane2,
  output logic [1:0]        state,
  output logic              confirmOk,
  output logic              confirmErr,
  output logic              dirty
);

  typedef enum logic [1:0] {RR = 2'd0, GG = 2'd1, YY = 2'd2} light_e;

  localparam int CNT_W = (REPEAT_DLY < 1) ? 1 : $clog2(REPEAT_DLY + 1);
  localparam logic [TIME_W-1:0] MIN_V    = TIME_W'(MIN_TIME);
  localparam logic [TIME_W-1:0] MAX_V    = TIME_W'(MAX_TIME);
  localparam logic [CNT_W-1:0]  DLY_V    = CNT_W'(REPEAT_DLY);
  localparam logic [CNT_W-1:0]  RELOAD_V = CNT_W'(REPEAT_DLY - REPEAT_PER + 1);

  light_e            cur, n_state;
  logic [TIME_W-1:0] red_t, green_t, yellow_t, disp;
  logic [TIME_W-1:0] n_red, n_green, n_yellow, n_rm, n_gm, n_ym, n_disp;
  logic [TIME_W-1:0] sel_t, new_t;
  logic              n_ok, n_err, n_dirty;
  logic              prev_change, prev_inc, prev_dec, prev_confirm, prev_cancel;
  logic [CNT_W-1:0]  cnt_inc, cnt_dec;
  logic              ev_change, ev_inc, ev_dec, ev_confirm, ev_cancel, valid;
  logic [TIME_W:0]   gy_sum;

  function automatic logic [TIME_W-1:0] clamp(input logic [TIME_W-1:0] v);
    if (v < MIN_V) return MIN_V;
    if (v > MAX_V) return MAX_V;
    return v;
  endfunction

  function automatic logic [TIME_W-1:0] step_up(input logic [TIME_W-1:0] v);
    if (v >= MAX_V) return (WRAP != 0) ? MIN_V : MAX_V;
    return v + 1'b1;
  endfunction

  function automatic logic [TIME_W-1:0] step_dn(input logic [TIME_W-1:0] v);
    if (v <= MIN_V) return (WRAP != 0) ? MAX_V : MIN_V;
    return v - 1'b1;
  endfunction

  assign state     = cur;
  assign timeLane1 = disp;
  assign timeLane2 = disp;

  // The hold counter sits at DLY_V exactly on each repeat cycle, then reloads
  // so the next hit comes REPEAT_PER cycles later.
  assign ev_change  = buttonChangeLight & ~prev_change;
  assign ev_inc     = buttonIncreaseTime & (~prev_inc | (cnt_inc == DLY_V));
  assign ev_dec     = buttonDecreaseTime & (~prev_dec | (cnt_dec == DLY_V));
  assign ev_confirm = buttonConfirm & ~prev_confirm;
  assign ev_cancel  = buttonCancel & ~prev_cancel;

  assign gy_sum = {1'b0, green_t} + {1'b0, yellow_t};
  assign valid  = (red_t > green_t) && (red_t > yellow_t) && ({1'b0, red_t} == gy_sum);

  always_comb begin
    n_state  = cur;
    n_red    = red_t;
    n_green  = green_t;
    n_yellow = yellow_t;
    n_rm     = redTimeModified;
    n_gm     = greenTimeModified;
    n_ym     = yellowTimeModified;
    n_disp   = disp;
    n_ok     = 1'b0;
    n_err    = 1'b0;
    case (cur)
      GG:      sel_t = green_t;
      YY:      sel_t = yellow_t;
      default: sel_t = red_t;
    endcase
    new_t = ev_inc ? step_up(sel_t) : step_dn(sel_t);

    if (!enable) begin
      n_state  = RR;
      n_red    = clamp(redTime);
      n_green  = clamp(greenTime);
      n_yellow = clamp(yellowTime);
      n_rm     = n_red;
      n_gm     = n_green;
      n_ym     = n_yellow;
      n_disp   = n_red;
    end else if (ev_cancel) begin
      n_red    = redTimeModified;
      n_green  = greenTimeModified;
      n_yellow = yellowTimeModified;
      case (cur)
        GG:      n_disp = greenTimeModified;
        YY:      n_disp = yellowTimeModified;
        default: n_disp = redTimeModified;
      endcase
    end else if (ev_confirm) begin
      if (valid) begin
        n_rm = red_t;
        n_gm = green_t;
        n_ym = yellow_t;
        n_ok = 1'b1;
      end else begin
        n_err = 1'b1;
      end
    end else if (ev_change) begin
      case (cur)
        RR: begin n_state = GG; n_disp = green_t;  end
        GG: begin n_state = YY; n_disp = yellow_t; end
        default: begin n_state = RR; n_disp = red_t; end
      endcase
    end else if (ev_inc ^ ev_dec) begin
      case (cur)
        GG:      n_green  = new_t;
        YY:      n_yellow = new_t;
        default: n_red    = new_t;
      endcase
      n_disp = new_t;
    end

    n_dirty = (n_red != n_rm) || (n_green != n_gm) || (n_yellow != n_ym);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur                <= RR;
      red_t              <= clamp(redTime);
      green_t            <= clamp(greenTime);
      yellow_t           <= clamp(yellowTime);
      redTimeModified    <= clamp(redTime);
      greenTimeModified  <= clamp(greenTime);
      yellowTimeModified <= clamp(yellowTime);
      disp               <= clamp(redTime);
      confirmOk          <= 1'b0;
      confirmErr         <= 1'b0;
      dirty              <= 1'b0;
      prev_change        <= 1'b0;
      prev_inc           <= 1'b0;
      prev_dec           <= 1'b0;
      prev_confirm       <= 1'b0;
      prev_cancel        <= 1'b0;
      cnt_inc            <= '0;
      cnt_dec            <= '0;
    end else begin
      cur                <= n_state;
      red_t              <= n_red;
      green_t            <= n_green;
      yellow_t           <= n_yellow;
      redTimeModified    <= n_rm;
      greenTimeModified  <= n_gm;
      yellowTimeModified <= n_ym;
      disp               <= n_disp;
      confirmOk          <= n_ok;
      confirmErr         <= n_err;
      dirty              <= n_dirty;
      prev_change        <= buttonChangeLight;
      prev_inc           <= buttonIncreaseTime;
      prev_dec           <= buttonDecreaseTime;
      prev_confirm       <= buttonConfirm;
      prev_cancel        <= buttonCancel;
      if (!buttonIncreaseTime)  cnt_inc <= '0;
      else if (cnt_inc == DLY_V) cnt_inc <= RELOAD_V;
      else                       cnt_inc <= cnt_inc + 1'b1;
      if (!buttonDecreaseTime)  cnt_dec <= '0;
      else if (cnt_dec == DLY_V) cnt_dec <= RELOAD_V;
      else                       cnt_dec <= cnt_dec + 1'b1;
    end
  end

endmodule

// File: tb/tb_config_mode_param.sv
// Directed bench for config_mode_param: stimulus queues expected outputs
// tagged with a cycle number; a monitor pops and compares them.
module tb_config_mode_param;

  localparam int TW = 7;

  localparam int S_STATE = 0, S_LANE1 = 1, S_LANE2 = 2, S_RMOD = 3, S_GMOD = 4,
                 S_YMOD = 5, S_DIRTY = 6, S_OK = 7, S_ERR = 8, S_SATLANE = 9;

  localparam int B_CHANGE = 0, B_INC = 1, B_DEC = 2, B_CONFIRM = 3, B_CANCEL = 4;

  typedef struct {
    int    sel;
    int    val;
    int    due;
    string name;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, enable;
  logic [4:0]    btn;
  logic [TW-1:0] greenTime, yellowTime, redTime;
  logic [TW-1:0] gm, ym, rm, lane1, lane2;
  logic [TW-1:0] s_gm, s_ym, s_rm, s_lane1, s_lane2;
  logic [1:0]    st, s_st;
  logic          ok, err, drt, s_ok, s_err, s_drt;

  exp_t q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  config_mode_param #(.TIME_W(TW), .WRAP(1)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .buttonChangeLight(btn[B_CHANGE]), .buttonIncreaseTime(btn[B_INC]),
    .buttonDecreaseTime(btn[B_DEC]), .buttonConfirm(btn[B_CONFIRM]),
    .buttonCancel(btn[B_CANCEL]),
    .greenTime(greenTime), .yellowTime(yellowTime), .redTime(redTime),
    .greenTimeModified(gm), .yellowTimeModified(ym), .redTimeModified(rm),
    .timeLane1(lane1), .timeLane2(lane2), .state(st),
    .confirmOk(ok), .confirmErr(err), .dirty(drt)
  );

  config_mode_param #(.TIME_W(TW), .WRAP(0)) dut_sat (
    .clk(clk), .reset(reset), .enable(enable),
    .buttonChangeLight(btn[B_CHANGE]), .buttonIncreaseTime(btn[B_INC]),
    .buttonDecreaseTime(btn[B_DEC]), .buttonConfirm(btn[B_CONFIRM]),
    .buttonCancel(btn[B_CANCEL]),
    .greenTime(greenTime), .yellowTime(yellowTime), .redTime(redTime),
    .greenTimeModified(s_gm), .yellowTimeModified(s_ym), .redTimeModified(s_rm),
    .timeLane1(s_lane1), .timeLane2(s_lane2), .state(s_st),
    .confirmOk(s_ok), .confirmErr(s_err), .dirty(s_drt)
  );

  function automatic int observe(input int sel);
    case (sel)
      S_STATE:   return int'(st);
      S_LANE1:   return int'(lane1);
      S_LANE2:   return int'(lane2);
      S_RMOD:    return int'(rm);
      S_GMOD:    return int'(gm);
      S_YMOD:    return int'(ym);
      S_DIRTY:   return int'(drt);
      S_OK:      return int'(ok);
      S_ERR:     return int'(err);
      S_SATLANE: return int'(s_lane1);
      default:   return -1;
    endcase
  endfunction

  // Monitor: compares every expectation whose cycle has been reached.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      int   act;
      e   = q.pop_front();
      act = observe(e.sel);
      vectors = vectors + 1;
      if (act != e.val) begin
        miscompares = miscompares + 1;
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", e.name, act, e.val, cyc);
      end
    end
  end

  task automatic expect_now(input int sel, input int val, input string name);
    exp_t e;
    e.sel = sel; e.val = val; e.due = cyc; e.name = name;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int b);
    btn[b] = 1'b1;
    step();
  endtask

  task automatic release_all();
    btn = '0;
    step();
  endtask

  task automatic pulse(input int b, input int times);
    for (int i = 0; i < times; i++) begin
      press(b);
      release_all();
    end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; btn = '0;
    redTime = 7'd30; greenTime = 7'd25; yellowTime = 7'd5;
    step(); step();
    expect_now(S_STATE, 0, "reset_state");
    expect_now(S_LANE1, 30, "reset_lane1");
    expect_now(S_LANE2, 30, "reset_lane2");
    expect_now(S_RMOD, 30, "reset_rmod");
    expect_now(S_GMOD, 25, "reset_gmod");
    expect_now(S_YMOD, 5, "reset_ymod");
    expect_now(S_DIRTY, 0, "reset_dirty");
    expect_now(S_OK, 0, "reset_ok");
    expect_now(S_ERR, 0, "reset_err");

    // Limits, with red loaded at 99 through the disabled path.
    reset = 1'b1; redTime = 7'd99;
    step();
    expect_now(S_LANE1, 99, "load_red99");
    enable = 1'b1;
    step();
    press(B_INC);
    expect_now(S_LANE1, 1, "wrap_inc_99");
    expect_now(S_SATLANE, 99, "sat_inc_99");
    expect_now(S_DIRTY, 1, "wrap_dirty");
    release_all();
    press(B_DEC);
    expect_now(S_LANE1, 99, "wrap_dec_1");
    expect_now(S_SATLANE, 98, "sat_dec_99");
    expect_now(S_DIRTY, 0, "wrap_back_clean");
    release_all();
    enable = 1'b0; redTime = 7'd120;
    step();
    expect_now(S_LANE1, 99, "clamp_high");
    expect_now(S_RMOD, 99, "clamp_high_mod");

    redTime = 7'd30;
    step();
    expect_now(S_RMOD, 30, "reload_rmod");
    enable = 1'b1;
    step();

    // Held increase: events at hold cycles 0, 50 and 60.
    btn[B_INC] = 1'b1;
    for (int i = 0; i < 70; i++) begin
      step();
      if (i == 0)  expect_now(S_LANE1, 31, "rpt_edge");
      if (i == 49) expect_now(S_LANE1, 31, "rpt_before_dly");
      if (i == 50) expect_now(S_LANE1, 32, "rpt_first");
      if (i == 59) expect_now(S_LANE1, 32, "rpt_before_per");
      if (i == 60) expect_now(S_LANE1, 33, "rpt_second");
    end
    release_all();
    expect_now(S_LANE1, 33, "rpt_end");
    press(B_INC);
    expect_now(S_LANE1, 34, "rpt_repress");
    release_all();
    press(B_CANCEL);
    expect_now(S_LANE1, 30, "cancel_red");
    expect_now(S_DIRTY, 0, "cancel_red_clean");
    release_all();

    // Confirm failure then success.
    pulse(B_CHANGE, 1);
    expect_now(S_STATE, 1, "to_gg");
    expect_now(S_LANE1, 25, "to_gg_lane");
    pulse(B_DEC, 5);
    expect_now(S_LANE1, 20, "green20");
    press(B_CONFIRM);
    expect_now(S_ERR, 1, "confirm_err");
    expect_now(S_OK, 0, "confirm_err_nook");
    expect_now(S_GMOD, 25, "err_gmod");
    expect_now(S_RMOD, 30, "err_rmod");
    expect_now(S_YMOD, 5, "err_ymod");
    expect_now(S_DIRTY, 1, "err_dirty");
    expect_now(S_STATE, 1, "err_state");
    release_all();
    expect_now(S_ERR, 0, "err_one_cycle");
    pulse(B_CHANGE, 1);
    expect_now(S_STATE, 2, "to_yy");
    expect_now(S_LANE1, 5, "to_yy_lane");
    pulse(B_INC, 5);
    expect_now(S_LANE1, 10, "yellow10");
    press(B_CONFIRM);
    expect_now(S_OK, 1, "confirm_ok");
    expect_now(S_ERR, 0, "confirm_ok_noerr");
    expect_now(S_RMOD, 30, "ok_rmod");
    expect_now(S_GMOD, 20, "ok_gmod");
    expect_now(S_YMOD, 10, "ok_ymod");
    expect_now(S_DIRTY, 0, "ok_dirty");
    expect_now(S_LANE1, 10, "ok_lane");
    release_all();
    expect_now(S_OK, 0, "ok_one_cycle");

    // Cancel in GG.
    pulse(B_CHANGE, 1);
    expect_now(S_STATE, 0, "yy_to_rr");
    expect_now(S_LANE1, 30, "rr_lane");
    pulse(B_CHANGE, 1);
    expect_now(S_LANE1, 20, "gg_lane20");
    pulse(B_INC, 2);
    expect_now(S_LANE1, 22, "green22");
    expect_now(S_DIRTY, 1, "green22_dirty");
    press(B_CANCEL);
    expect_now(S_LANE1, 20, "cancel_lane1");
    expect_now(S_LANE2, 20, "cancel_lane2");
    expect_now(S_DIRTY, 0, "cancel_dirty");
    expect_now(S_STATE, 1, "cancel_state");
    release_all();

    // Simultaneous events.
    btn[B_INC] = 1'b1; btn[B_DEC] = 1'b1;
    step();
    expect_now(S_LANE1, 20, "incdec_nochange");
    expect_now(S_DIRTY, 0, "incdec_clean");
    release_all();
    btn[B_CONFIRM] = 1'b1; btn[B_CHANGE] = 1'b1;
    step();
    expect_now(S_STATE, 1, "confchg_state");
    expect_now(S_OK, 1, "confchg_ok");
    release_all();
    pulse(B_INC, 1);
    expect_now(S_LANE1, 21, "green21");
    expect_now(S_DIRTY, 1, "green21_dirty");
    enable = 1'b0;
    step();
    expect_now(S_STATE, 0, "drop_state");
    expect_now(S_LANE1, 30, "drop_lane");
    expect_now(S_RMOD, 30, "drop_rmod");
    expect_now(S_GMOD, 25, "drop_gmod");
    expect_now(S_YMOD, 5, "drop_ymod");
    expect_now(S_DIRTY, 0, "drop_dirty");

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    if (q.size() > 0) begin
      miscompares = miscompares + 1;
      $display("FAIL drain: %0d pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
